layer1_sequencer: RTL and testbench
===================================

// Module: layer1_sequencer
// PURPOSE
//  Sequences one stage-1 inference pass through the 32-MAC layer-1 array: clears the accumulators,
//  streams N_PIX image pixels plus matching weight-row addresses, drains the pipeline, then freezes
//  the array and raises done. Sits between the CPU register interface (go/done/ack) and the
//  image/weight memories feeding the layer-1 array.
// PARAMETERS
//  N_PIX   784  pixels per image (MNIST 28x28)
//  ADDR_W  10   image/weight address width; must satisfy 2**ADDR_W >= N_PIX
//  DRAIN   2    zero-pixel cycles after last pixel before the array is frozen
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  resetn     in   1       asynchronous active-low reset
//  go         in   1       start a pass; sampled only in IDLE
//  abort      in   1       synchronous abort; returns to IDLE, no done
//  ack        in   1       acknowledges done; sampled only in DONE
//  busy       out  1       high in CLR, STREAM and DRAIN
//  done       out  1       high in DONE; array outputs stable and valid
//  img_rd     out  1       image memory read strobe
//  img_addr   out  ADDR_W  image memory address
//  img_data   in   32      image memory read data, valid 1 cycle after img_rd
//  w_addr     out  ADDR_W  weight-row address (32 weights per row, read latency 1)
//  arr_start  out  1       to array start (clears im register and accumulators)
//  arr_stop   out  1       to array stop (freezes accumulators)
//  arr_image  out  32      to array image input
//  cyc_cnt    out  16      cycles spent in last/current pass (CLR to DONE entry)
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE; busy=done=img_rd=arr_start=0; arr_stop=1;
//   img_addr=w_addr=0; arr_image=0; cyc_cnt=0. Deassertion takes effect at next clk edge.
//  FSM: IDLE -> CLR -> STREAM -> DRAIN -> DONE -> IDLE.
//   IDLE:   arr_stop=1. go=1 -> CLR; cyc_cnt cleared.
//   CLR:    exactly 1 cycle; arr_start=1, arr_stop=0; img_rd=1, img_addr=0 issued. -> STREAM.
//   STREAM: N_PIX-1 cycles; img_addr increments 1..N_PIX-1, img_rd=1. After the cycle that
//           issues N_PIX-1 -> DRAIN.
//   DRAIN:  DRAIN+1 cycles; img_rd=0. -> DONE.
//   DONE:   arr_stop=1, done=1, busy=0; held until ack=1 -> IDLE (done drops next cycle).
//  Alignment: pixel k addressed at cycle t (img_addr=k); arr_image=img_data for k at t+1;
//   w_addr=k at t+1 (img_addr delayed 1 cycle), so weight row k and the array im register
//   both present pixel k at t+2. Whenever no read was issued the previous cycle,
//   arr_image=0, so drain cycles add zero to every accumulator.
//  Exactly N_PIX nonzero-eligible products reach each MAC per pass, no more, no fewer.
//  cyc_cnt: +1 per cycle in CLR/STREAM/DRAIN, saturates at 16'hFFFF, frozen in DONE/IDLE
//   until the next go. Nominal value = 1 + (N_PIX-1) + (DRAIN+1) = N_PIX+DRAIN+1.
//  abort=1 in CLR/STREAM/DRAIN: next state IDLE; arr_stop=1; img_rd=0; done stays 0;
//   accumulators hold partial results (undefined for software). abort in IDLE/DONE ignored.
//  abort and ack both high in DONE: ack wins (-> IDLE, same result).
//  go while not IDLE is ignored (no queueing). go and ack both high in DONE: only ack acts;
//   a new pass needs go in IDLE.
//  Address wrap: img_addr never exceeds N_PIX-1; w_addr never exceeds N_PIX-1.
// TESTING
//  1 Reset: resetn=0 mid-STREAM (pixel 300) -> same cycle busy=0, arr_stop=1, img_rd=0;
//    after release, go starts a clean pass with img_addr=0.
//  2 Full pass, all pixels=1, all weights=1 -> done after 787 cycles (N_PIX=784, DRAIN=2);
//    every p0..p31=784; cyc_cnt=787.
//  3 Ramp: pixel k=k, weight row k=1 for neuron 0 only -> p0=306936, p1..p31=0; checks alignment.
//  4 Off-by-one: only pixel 0 and pixel 783 nonzero (5, 7), weights=2 -> p*=24.
//  5 Abort at pixel 100 -> IDLE next cycle, done never asserted; next go/ack pass gives correct
//    results (proves CLR clears partials).
//  6 Handshake: go held high through a pass and ack delayed 10 cycles -> done held 10 cycles,
//    no second pass until go re-sampled in IDLE; go in STREAM ignored.

Source files
------------

// File: rtl/layer1_sequencer_if.sv
// Purpose: bundles the sequencer's CPU handshake, memory-read and array-control signals.
// Latency: none; plain wires between the sequencer and its environment.
// Backpressure: none on the bus; the go/done/ack handshake is the only flow control.
interface layer1_sequencer_if #(
  parameter int ADDR_W = 10
);
  // CPU register side
  logic              go;
  logic              abort;
  logic              ack;
  logic              busy;
  logic              done;
  // image / weight memory side
  logic              img_rd;
  logic [ADDR_W-1:0] img_addr;
  logic [31:0]       img_data;
  logic [ADDR_W-1:0] w_addr;
  // layer-1 array side
  logic              arr_start;
  logic              arr_stop;
  logic [31:0]       arr_image;
  // pass statistics
  logic [15:0]       cyc_cnt;

  // sequencer end: drives strobes, addresses and array control
  modport master (
    input  go, abort, ack, img_data,
    output busy, done, img_rd, img_addr, w_addr,
           arr_start, arr_stop, arr_image, cyc_cnt
  );

  // environment end: CPU registers, memories and the array
  modport slave (
    output go, abort, ack, img_data,
    input  busy, done, img_rd, img_addr, w_addr,
           arr_start, arr_stop, arr_image, cyc_cnt
  );
endinterface

// File: rtl/layer1_sequencer.sv
// Purpose: runs one layer-1 pass: clear array, stream N_PIX pixels/weight rows, drain, freeze, done.
// Latency: done rises N_PIX+DRAIN+1 cycles after the CLR cycle that follows go.
// Backpressure: none; pixels stream at one per cycle, done is held until ack, go ignored unless idle.
module layer1_sequencer #(
  parameter int N_PIX  = 784,
  parameter int ADDR_W = 10,
  parameter int DRAIN  = 2
) (
  input  logic                clk,
  input  logic                resetn,
  layer1_sequencer_if.master  bus
);

  localparam int DW = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIX - 1);
  localparam logic [DW-1:0]     LAST_DRN = DW'(DRAIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;   // address being issued this cycle
  logic [ADDR_W-1:0] wa_q, wa_d;     // img_addr delayed one cycle -> weight row
  logic [DW-1:0]     drn_q, drn_d;
  logic [15:0]       cyc_q, cyc_d;
  logic              rd_q, rd_d;     // a read was issued last cycle

  logic              busy_c;
  logic              done_c;
  logic              img_rd_c;
  logic              arr_start_c;
  logic              arr_stop_c;
  logic [15:0]       cyc_inc;

  assign cyc_inc = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

  // next-state, counters and per-state outputs; abort overrides the busy states
  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    drn_d       = drn_q;
    cyc_d       = cyc_q;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    img_rd_c    = 1'b0;
    arr_start_c = 1'b0;
    arr_stop_c  = 1'b1;

    case (state_q)
      S_IDLE: begin
        pix_d = '0;
        if (bus.go) begin
          state_d = S_CLR;
          cyc_d   = '0;
        end
      end
      S_CLR: begin
        busy_c      = 1'b1;
        arr_start_c = 1'b1;
        arr_stop_c  = 1'b0;
        img_rd_c    = 1'b1;
        cyc_d       = cyc_inc;
        if (N_PIX == 1) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end else begin
          state_d = S_STREAM;
          pix_d   = ADDR_W'(1);
        end
      end
      S_STREAM: begin
        busy_c     = 1'b1;
        arr_stop_c = 1'b0;
        img_rd_c   = 1'b1;
        cyc_d      = cyc_inc;
        if (pix_q == LAST_PIX) begin
          state_d = S_DRAIN;
          pix_d   = '0;
          drn_d   = '0;
        end else begin
          pix_d = pix_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        busy_c     = 1'b1;
        arr_stop_c = 1'b0;
        cyc_d      = cyc_inc;
        if (drn_q == LAST_DRN) begin
          state_d = S_DONE;
        end else begin
          drn_d = drn_q + DW'(1);
        end
      end
      S_DONE: begin
        done_c = 1'b1;
        if (bus.ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort mid-pass: stop reading and freeze the array right away, no done
    if (bus.abort && busy_c) begin
      state_d    = S_IDLE;
      pix_d      = '0;
      img_rd_c   = 1'b0;
      arr_stop_c = 1'b1;
    end
  end

  // the weight row trails the image address by one cycle so both meet pixel k at the array
  always_comb begin
    wa_d = pix_q;
    rd_d = img_rd_c;
  end

  // state and pipeline registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      wa_q    <= '0;
      drn_q   <= '0;
      cyc_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      wa_q    <= wa_d;
      drn_q   <= drn_d;
      cyc_q   <= cyc_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.img_rd    = img_rd_c;
  assign bus.img_addr  = pix_q;
  assign bus.w_addr    = wa_q;
  assign bus.arr_start = arr_start_c;
  assign bus.arr_stop  = arr_stop_c;
  // zero when nothing was read, so drain cycles add nothing to the accumulators
  assign bus.arr_image = rd_q ? bus.img_data : 32'd0;
  assign bus.cyc_cnt   = cyc_q;

endmodule

// File: tb/tb_layer1_sequencer.sv
// Purpose: exercises layer1_sequencer with memory and 32-MAC array models around it.
// Latency: each pass is expected to reach done N_PIX+DRAIN+1 cycles after CLR.
// Backpressure: ack delay is varied to hold done; go/abort exercise the handshake corners.
module tb_layer1_sequencer;
  localparam int N_PIX   = 784;
  localparam int ADDR_W  = 10;
  localparam int DRAIN   = 2;
  localparam int NN      = 32;
  localparam int NOM_CYC = N_PIX + DRAIN + 1;  // 787

  typedef struct {
    int cyc;
    int p0;
    int prest;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  layer1_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  layer1_sequencer #(
    .N_PIX (N_PIX),
    .ADDR_W(ADDR_W),
    .DRAIN (DRAIN)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  int imem [N_PIX];
  int wmem [N_PIX][NN];
  int wreg [NN];
  int im;
  int acc  [NN];

  // image memory, weight memory and array model: im register plus accumulators
  always @(posedge clk) begin
    if (bus.img_rd) bus.img_data <= imem[bus.img_addr];
    for (int n = 0; n < NN; n++) wreg[n] <= wmem[bus.w_addr][n];
    if (bus.arr_start) begin
      im <= 0;
      for (int n = 0; n < NN; n++) acc[n] <= 0;
    end else begin
      im <= bus.arr_image;
      if (!bus.arr_stop)
        for (int n = 0; n < NN; n++) acc[n] <= acc[n] + im * wreg[n];
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every rising done pops one expected result and compares
  initial begin : monitor
    bit   prev;
    exp_t e;
    int   bad;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn && bus.done && !prev) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected no pass pending");
        end else begin
          e = sb_q.pop_front();
          chk("cyc_cnt", bus.cyc_cnt, e.cyc);
          chk("p0", acc[0], e.p0);
          bad = 1;
          for (int n = NN - 1; n >= 1; n--) if (acc[n] != e.prest) bad = n;
          chk($sformatf("p%0d", bad), acc[bad], e.prest);
        end
      end
      prev = bus.done;
    end
  end

  task automatic load(input int mode);
    for (int k = 0; k < N_PIX; k++) begin
      for (int n = 0; n < NN; n++) wmem[k][n] = 0;
      case (mode)
        0: begin  // all ones
          imem[k] = 1;
          for (int n = 0; n < NN; n++) wmem[k][n] = 1;
        end
        1: begin  // ramp, neuron 0 only
          imem[k]    = k;
          wmem[k][0] = 1;
        end
        default: begin  // first and last pixel only
          imem[k] = (k == 0) ? 5 : (k == N_PIX - 1) ? 7 : 0;
          for (int n = 0; n < NN; n++) wmem[k][n] = 2;
        end
      endcase
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got done=0 expected done within 3000 cycles");
    end
  endtask

  task automatic wait_addr(input int a);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = (int'(bus.img_addr) == a) && bus.img_rd;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL addr_timeout: got no img_addr=%0d expected it within 2000 cycles", a);
    end
  endtask

  // go pulse, CLR-cycle checks, then wait for done and ack after ack_dly cycles
  task automatic run_pass(input int ack_dly);
    @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    chk("clr_start", bus.arr_start, 1);
    chk("clr_img_rd", bus.img_rd, 1);
    chk("clr_img_addr", bus.img_addr, 0);
    wait_done();
    repeat (ack_dly) @(negedge clk);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("done_after_ack", bus.done, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  dcnt;
    exp_t e;
    bus.go    = 1'b0;
    bus.abort = 1'b0;
    bus.ack   = 1'b0;

    // reset values
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_img_rd", bus.img_rd, 0);
    chk("rst_arr_start", bus.arr_start, 0);
    chk("rst_arr_stop", bus.arr_stop, 1);
    chk("rst_img_addr", bus.img_addr, 0);
    chk("rst_w_addr", bus.w_addr, 0);
    chk("rst_arr_image", bus.arr_image, 0);
    chk("rst_cyc_cnt", bus.cyc_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;

    // full pass of ones
    load(0);
    e = '{NOM_CYC, 784, 784};
    sb_q.push_back(e);
    run_pass(0);

    // ramp on neuron 0: sum 0..783
    load(1);
    e = '{NOM_CYC, 306936, 0};
    sb_q.push_back(e);
    run_pass(2);

    // only first and last pixel: (5+7)*2
    load(2);
    e = '{NOM_CYC, 24, 24};
    sb_q.push_back(e);
    run_pass(1);

    // abort at pixel 100, then a clean pass must not see the partial sums
    load(0);
    @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    wait_addr(100);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_arr_stop", bus.arr_stop, 1);
    chk("abort_img_rd", bus.img_rd, 0);
    dcnt = 0;
    repeat (900) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    e = '{NOM_CYC, 784, 784};
    sb_q.push_back(e);
    run_pass(0);

    // asynchronous reset at pixel 300
    @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    wait_addr(300);
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_arr_stop", bus.arr_stop, 1);
    chk("mid_rst_img_rd", bus.img_rd, 0);
    chk("mid_rst_arr_image", bus.arr_image, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    e = '{NOM_CYC, 784, 784};
    sb_q.push_back(e);
    run_pass(0);

    // go held through the pass and in DONE, ack after 10 cycles
    e = '{NOM_CYC, 784, 784};
    sb_q.push_back(e);
    @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    chk("hold_clr_start", bus.arr_start, 1);
    wait_done();
    dcnt = 0;
    repeat (10) begin
      if (bus.done) dcnt++;
      @(negedge clk);
    end
    chk("done_hold_cycles", dcnt, 10);
    chk("done_still_high", bus.done, 1);
    bus.ack = 1'b1;
    @(negedge clk);
    chk("go_ack_idle_busy", bus.busy, 0);
    chk("go_ack_idle_done", bus.done, 0);
    bus.go  = 1'b0;
    bus.ack = 1'b0;
    @(negedge clk);
    chk("stay_idle_busy", bus.busy, 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
